// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the ibus/dbus to system-bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    I_RESP,
    D_REQ,
    D_RESP
  } arb_state_t;

  localparam int unsigned TAG_WRITE_BIT = 12;
  localparam int unsigned BEATS         = 8;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (ibus/dbus) arbiter onto the single system bus: one transaction
// outstanding, round-robin on ties, combinational routing inside a grant.
module bus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = bus_arbiter_pkg::TAG_WRITE_BIT + 1,
  parameter int unsigned BEATS          = bus_arbiter_pkg::BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
  input  logic                      ibus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
  output logic                      ibus_reqack,
  output logic                      ibus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
  input  logic                      ibus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
  input  logic                      dbus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
  output logic                      dbus_reqack,
  output logic                      dbus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
  input  logic                      dbus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic                      bus_reqcyc,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);
  import bus_arbiter_pkg::*;

  localparam int unsigned WR_BIT    = BUS_TAG_WIDTH - 1;
  localparam logic [3:0]  LAST_WR   = 4'(BEATS);
  localparam logic [3:0]  LAST_RESP = 4'(BEATS - 1);

  arb_state_t state;
  logic [3:0] beat_cnt;
  logic       last_d;

  logic                      req_phase, resp_phase, sel_d;
  logic                      own_reqcyc, own_respack;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      req_beat, resp_beat;

  assign req_phase   = (state == I_REQ)  || (state == D_REQ);
  assign resp_phase  = (state == I_RESP) || (state == D_RESP);
  assign sel_d       = (state == D_REQ)  || (state == D_RESP);

  assign own_reqcyc  = sel_d ? dbus_reqcyc  : ibus_reqcyc;
  assign own_req     = sel_d ? dbus_req     : ibus_req;
  assign own_reqtag  = sel_d ? dbus_reqtag  : ibus_reqtag;
  assign own_respack = sel_d ? dbus_respack : ibus_respack;

  assign req_beat    = req_phase  && own_reqcyc  && bus_reqack;
  assign resp_beat   = resp_phase && bus_respcyc && own_respack;

  // Response data/tag are broadcast; only forced low while reset is held.
  assign ibus_resp    = reset ? '0 : bus_resp;
  assign dbus_resp    = reset ? '0 : bus_resp;
  assign ibus_resptag = reset ? '0 : bus_resptag;
  assign dbus_resptag = reset ? '0 : bus_resptag;

  always_comb begin
    bus_req      = '0;
    bus_reqcyc   = 1'b0;
    bus_reqtag   = '0;
    ibus_reqack  = 1'b0;
    dbus_reqack  = 1'b0;
    ibus_respcyc = 1'b0;
    dbus_respcyc = 1'b0;
    bus_respack  = 1'b0;
    if (req_phase) begin
      bus_req     = own_req;
      bus_reqcyc  = own_reqcyc;
      bus_reqtag  = own_reqtag;
      ibus_reqack = !sel_d && bus_reqack;
      dbus_reqack = sel_d  && bus_reqack;
    end
    if (resp_phase) begin
      ibus_respcyc = !sel_d && bus_respcyc;
      dbus_respcyc = sel_d  && bus_respcyc;
      bus_respack  = own_respack;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_d   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          // On a tie the master that was not granted last wins.
          if (dbus_reqcyc && (!ibus_reqcyc || !last_d)) begin
            state  <= D_REQ;
            last_d <= 1'b1;
          end else if (ibus_reqcyc) begin
            state  <= I_REQ;
            last_d <= 1'b0;
          end
        end
        I_REQ, D_REQ: begin
          if (req_beat) begin
            if (!own_reqtag[WR_BIT]) begin
              state    <= sel_d ? D_RESP : I_RESP;
              beat_cnt <= '0;
            end else if (beat_cnt == LAST_WR) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end else if (!own_reqcyc && (beat_cnt == '0)) begin
            state <= IDLE;
          end
        end
        I_RESP, D_RESP: begin
          if (resp_beat) begin
            if (beat_cnt == LAST_RESP) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reads, writes, ties,
// wait states, withheld response acks, released grants and mid-transfer reset.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ibus_req, dbus_req, ibus_resp, dbus_resp, bus_req, bus_resp;
  logic        ibus_reqcyc, dbus_reqcyc, ibus_reqack, dbus_reqack;
  logic        ibus_respcyc, dbus_respcyc, ibus_respack, dbus_respack;
  logic [12:0] ibus_reqtag, dbus_reqtag, ibus_resptag, dbus_resptag;
  logic [12:0] bus_reqtag, bus_resptag;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(8)) dut (
    .clk(clk), .reset(reset),
    .ibus_req(ibus_req), .ibus_reqcyc(ibus_reqcyc), .ibus_reqtag(ibus_reqtag),
    .ibus_reqack(ibus_reqack), .ibus_respcyc(ibus_respcyc), .ibus_resp(ibus_resp),
    .ibus_resptag(ibus_resptag), .ibus_respack(ibus_respack),
    .dbus_req(dbus_req), .dbus_reqcyc(dbus_reqcyc), .dbus_reqtag(dbus_reqtag),
    .dbus_reqack(dbus_reqack), .dbus_respcyc(dbus_respcyc), .dbus_resp(dbus_resp),
    .dbus_resptag(dbus_resptag), .dbus_respack(dbus_respack),
    .bus_req(bus_req), .bus_reqcyc(bus_reqcyc), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input bit d, input logic cyc, input logic [63:0] req,
                       input logic [12:0] tag, input logic rack);
    if (d) begin
      dbus_reqcyc = cyc; dbus_req = req; dbus_reqtag = tag; dbus_respack = rack;
    end else begin
      ibus_reqcyc = cyc; ibus_req = req; ibus_reqtag = tag; ibus_respack = rack;
    end
  endtask

  function automatic logic m_reqack(input bit d);
    return d ? dbus_reqack : ibus_reqack;
  endfunction

  function automatic logic m_respcyc(input bit d);
    return d ? dbus_respcyc : ibus_respcyc;
  endfunction

  function automatic logic [63:0] m_resp(input bit d);
    return d ? dbus_resp : ibus_resp;
  endfunction

  function automatic logic [12:0] rd_tag(input bit d);
    return d ? 13'h0155 : 13'h00A5;
  endfunction

  // pend: the grant edge already happened at the end of the previous step.
  task automatic read_txn(input bit d, input logic [63:0] addr, input bit pend,
                          input int ack_wait, input int hold_beat, input int hold_cycles);
    logic [63:0] val;
    set_m(d, 1'b1, addr, rd_tag(d), 1'b0);
    bus_reqack = 1'b0;
    if (!pend) begin
      #1;
      check_eq("rd_idle_busreqcyc", bus_reqcyc, 1'b0);
      check_eq("rd_idle_reqack", m_reqack(d), 1'b0);
      tick();
    end
    for (int w = 0; w < ack_wait; w++) begin
      #1;
      check_eq("rd_wait_busreqcyc", bus_reqcyc, 1'b1);
      check_eq("rd_wait_busreq", bus_req, addr);
      check_eq("rd_wait_reqack", m_reqack(d), 1'b0);
      tick();
    end
    bus_reqack = 1'b1;
    #1;
    check_eq("rd_grant_busreqcyc", bus_reqcyc, 1'b1);
    check_eq("rd_grant_busreq", bus_req, addr);
    check_eq("rd_grant_busreqtag", bus_reqtag, rd_tag(d));
    check_eq("rd_grant_reqack", m_reqack(d), 1'b1);
    check_eq("rd_grant_other_reqack", m_reqack(!d), 1'b0);
    tick();
    bus_reqack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      val = 64'h11 * 64'(k + 1);
      if (k == hold_beat) begin
        for (int h = 0; h < hold_cycles; h++) begin
          bus_respcyc = 1'b1; bus_resp = val; bus_resptag = rd_tag(d);
          set_m(d, 1'b0, '0, '0, 1'b0);
          #1;
          check_eq($sformatf("rd_hold%0d_respcyc", h), m_respcyc(d), 1'b1);
          check_eq($sformatf("rd_hold%0d_busrespack", h), bus_respack, 1'b0);
          tick();
        end
      end
      bus_respcyc = 1'b1; bus_resp = val; bus_resptag = rd_tag(d);
      set_m(d, 1'b0, '0, '0, 1'b1);
      #1;
      check_eq($sformatf("rd_beat%0d_busreqcyc", k), bus_reqcyc, 1'b0);
      check_eq($sformatf("rd_beat%0d_respcyc", k), m_respcyc(d), 1'b1);
      check_eq($sformatf("rd_beat%0d_other_respcyc", k), m_respcyc(!d), 1'b0);
      check_eq($sformatf("rd_beat%0d_resp", k), m_resp(d), val);
      check_eq($sformatf("rd_beat%0d_other_resp", k), m_resp(!d), val);
      check_eq($sformatf("rd_beat%0d_busrespack", k), bus_respack, 1'b1);
      tick();
    end
    bus_respcyc = 1'b1; bus_resp = 64'hBAD;
    #1;
    check_eq("rd_after_stray_respcyc", m_respcyc(d), 1'b0);
    check_eq("rd_after_stray_busrespack", bus_respack, 1'b0);
    tick();
    bus_respcyc = 1'b0; bus_resp = '0;
    set_m(d, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic write_txn(input bit d, input logic [63:0] addr, input int ack_wait);
    logic [63:0] data;
    logic [12:0] tag;
    tag = 13'h1033;
    set_m(d, 1'b1, addr, tag, 1'b1);
    bus_reqack = 1'b0;
    #1;
    check_eq("wr_idle_busreqcyc", bus_reqcyc, 1'b0);
    tick();
    bus_respcyc = 1'b1; bus_resp = 64'hF00D;
    for (int b = 0; b < 9; b++) begin
      data = (b == 0) ? addr : addr + 64'h100 + 64'(b);
      set_m(d, 1'b1, data, tag, 1'b1);
      if (b == 1) begin
        for (int w = 0; w < ack_wait; w++) begin
          bus_reqack = 1'b0;
          #1;
          check_eq("wr_wait_busreqcyc", bus_reqcyc, 1'b1);
          check_eq("wr_wait_busreq", bus_req, data);
          check_eq("wr_wait_reqack", m_reqack(d), 1'b0);
          tick();
        end
      end
      bus_reqack = 1'b1;
      #1;
      check_eq($sformatf("wr_beat%0d_busreqcyc", b), bus_reqcyc, 1'b1);
      check_eq($sformatf("wr_beat%0d_busreq", b), bus_req, data);
      check_eq($sformatf("wr_beat%0d_busreqtag", b), bus_reqtag, tag);
      check_eq($sformatf("wr_beat%0d_reqack", b), m_reqack(d), 1'b1);
      check_eq($sformatf("wr_beat%0d_other_reqack", b), m_reqack(!d), 1'b0);
      check_eq($sformatf("wr_beat%0d_respcyc", b), m_respcyc(d), 1'b0);
      check_eq($sformatf("wr_beat%0d_other_respcyc", b), m_respcyc(!d), 1'b0);
      check_eq($sformatf("wr_beat%0d_busrespack", b), bus_respack, 1'b0);
      tick();
    end
    // Still requesting after nine beats: the arbiter must be back in IDLE.
    set_m(d, 1'b1, addr + 64'h999, tag, 1'b1);
    #1;
    check_eq("wr_done_busreqcyc", bus_reqcyc, 1'b0);
    check_eq("wr_done_reqack", m_reqack(d), 1'b0);
    check_eq("wr_done_respcyc", m_respcyc(d), 1'b0);
    set_m(d, 1'b0, '0, '0, 1'b0);
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_m(1'b0, 1'b1, 64'h1234, 13'h0001, 1'b1);
    set_m(1'b1, 1'b1, 64'h5678, 13'h1001, 1'b1);
    bus_reqack = 1'b1; bus_respcyc = 1'b1;
    bus_resp = 64'hDEAD; bus_resptag = 13'h0ABC;
    repeat (3) tick();
    check_eq("rst_busreqcyc", bus_reqcyc, 1'b0);
    check_eq("rst_busreq", bus_req, 64'h0);
    check_eq("rst_ibus_reqack", ibus_reqack, 1'b0);
    check_eq("rst_dbus_reqack", dbus_reqack, 1'b0);
    check_eq("rst_ibus_respcyc", ibus_respcyc, 1'b0);
    check_eq("rst_busrespack", bus_respack, 1'b0);
    check_eq("rst_ibus_resp", ibus_resp, 64'h0);
    check_eq("rst_dbus_resptag", dbus_resptag, 64'h0);
    set_m(1'b0, 1'b0, '0, '0, 1'b0);
    set_m(1'b1, 1'b0, '0, '0, 1'b0);
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    reset = 1'b0;
    tick();

    // Tie straight after reset: dbus first, ibus after one idle cycle.
    set_m(1'b0, 1'b1, 64'h3000, rd_tag(1'b0), 1'b0);
    write_txn(1'b1, 64'h2000, 0);
    read_txn(1'b0, 64'h3000, 1'b1, 0, -1, 0);

    read_txn(1'b0, 64'h1000, 1'b0, 0, -1, 0);
    write_txn(1'b1, 64'h2000, 3);
    read_txn(1'b1, 64'h4000, 1'b0, 2, 4, 2);

    // ibus drops its request before any accepted beat: grant released.
    set_m(1'b0, 1'b1, 64'h7000, rd_tag(1'b0), 1'b0);
    tick();
    #1;
    check_eq("drop_busreqcyc_held", bus_reqcyc, 1'b1);
    set_m(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check_eq("drop_busreqcyc_released", bus_reqcyc, 1'b0);
    tick();
    read_txn(1'b1, 64'h7100, 1'b0, 0, -1, 0);

    // Reset during the third response beat of an ibus read.
    set_m(1'b0, 1'b1, 64'h5000, rd_tag(1'b0), 1'b0);
    tick();
    bus_reqack = 1'b1;
    #1;
    check_eq("rstmid_reqack", ibus_reqack, 1'b1);
    tick();
    bus_reqack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_respcyc = 1'b1; bus_resp = 64'h11 * 64'(k + 1);
      set_m(1'b0, 1'b0, '0, '0, 1'b1);
      #1;
      check_eq($sformatf("rstmid_beat%0d_respcyc", k), ibus_respcyc, 1'b1);
      tick();
    end
    bus_respcyc = 1'b1; bus_resp = 64'h33;
    reset = 1'b1;
    #1;
    check_eq("rstmid_now_respcyc", ibus_respcyc, 1'b0);
    check_eq("rstmid_now_busrespack", bus_respack, 1'b0);
    check_eq("rstmid_now_resp", ibus_resp, 64'h0);
    tick();
    check_eq("rstmid_next_respcyc", ibus_respcyc, 1'b0);
    check_eq("rstmid_next_busrespack", bus_respack, 1'b0);
    check_eq("rstmid_next_busreqcyc", bus_reqcyc, 1'b0);
    check_eq("rstmid_next_dbus_resp", dbus_resp, 64'h0);
    reset = 1'b0;
    bus_respcyc = 1'b0; bus_resp = '0;
    set_m(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    read_txn(1'b1, 64'h6000, 1'b0, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
